// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS fixed-point systolic matrix-vector multiplier (y = a * B).
// Latency: ROWS+COLS cycles from input acceptance to out_valid when no stall occurs.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; SYSTOLIC_SAT_EN selects saturating arithmetic.
`timescale 1ns/1ps
module systolic_array #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10,
  parameter int ROWS     = 2,
  parameter int COLS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [COLS*WIDTH-1:0]   w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*WIDTH-1:0]   out_data
);

  localparam int DEPTH = ROWS + COLS;
  localparam int CW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] w      [ROWS][COLS];
  logic signed [WIDTH-1:0] a_pe   [ROWS][COLS];
  logic signed [WIDTH-1:0] a_feed [ROWS];
  logic signed [WIDTH-1:0] psum   [ROWS][COLS];
  logic signed [WIDTH-1:0] y      [COLS];
  logic [DEPTH-1:0]        vld;
  logic                    advance;
  logic                    accept;

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = ~PMAX;
  localparam logic signed [WIDTH-1:0]   WMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   WMIN = ~WMAX;
`endif

  // Fixed-point product: full-width multiply, arithmetic shift, then truncate or clamp
  function automatic logic signed [WIDTH-1:0] mul_fx(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] xe, be, full;
    xe   = {{WIDTH{x[WIDTH-1]}}, x};
    be   = {{WIDTH{b[WIDTH-1]}}, b};
    full = xe * be;
`ifdef SYSTOLIC_SAT_EN
    begin
      logic signed [2*WIDTH-1:0] sh;
      sh = full >>> FRAC_BIT;
      if (sh > PMAX)      return WMAX;
      else if (sh < PMIN) return WMIN;
      else                return sh[WIDTH-1:0];
    end
`else
    return WIDTH'(full >>> FRAC_BIT);
`endif
  endfunction

  // Accumulate: wraps modulo 2^WIDTH, or clamps when saturation is compiled in
  function automatic logic signed [WIDTH-1:0] add_fx(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] b);
`ifdef SYSTOLIC_SAT_EN
    logic signed [WIDTH:0] s;
    s = {x[WIDTH-1], x} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? WMIN : WMAX;
    return s[WIDTH-1:0];
`else
    return x + b;
`endif
  endfunction

  assign advance   = !out_valid || out_ready;
  assign out_valid = vld[DEPTH-1];
  assign in_ready  = (state == RUN) && advance && !w_valid;
  assign w_ready   = (state == LOAD);
  assign accept    = in_valid && in_ready;

  // Input skew: row r sees its element r cycles later so partial sums meet it in step
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign a_feed[r] = in_data[r*WIDTH +: WIDTH];
    end else begin : g_chain
      logic signed [WIDTH-1:0] sk [r];
      // Shift row element through r skew registers
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) sk[k] <= '0;
        end else if (advance) begin
          sk[0] <= in_data[r*WIDTH +: WIDTH];
          for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
        end
      end
      assign a_feed[r] = sk[r-1];
    end
  end

  // PE grid: activations move right, partial sums move down, weights stay put
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          a_pe[r][c] <= '0;
          psum[r][c] <= '0;
        end
    end else if (advance) begin
      for (int r = 0; r < ROWS; r++) a_pe[r][0] <= a_feed[r];
      for (int r = 0; r < ROWS; r++)
        for (int c = 1; c < COLS; c++) a_pe[r][c] <= a_pe[r][c-1];
      for (int c = 0; c < COLS; c++) psum[0][c] <= mul_fx(a_pe[0][c], w[0][c]);
      for (int r = 1; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          psum[r][c] <= add_fx(psum[r-1][c], mul_fx(a_pe[r][c], w[r][c]));
    end
  end

  // Output deskew: earlier columns wait so every column of a beat emerges together
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    if (c == COLS - 1) begin : g_direct
      assign y[c] = psum[ROWS-1][c];
    end else begin : g_chain
      logic signed [WIDTH-1:0] ds [COLS-1-c];
      // Delay column c by COLS-1-c registers
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < COLS - 1 - c; k++) ds[k] <= '0;
        end else if (advance) begin
          ds[0] <= psum[ROWS-1][c];
          for (int k = 1; k < COLS - 1 - c; k++) ds[k] <= ds[k-1];
        end
      end
      assign y[c] = ds[COLS-2-c];
    end
    assign out_data[c*WIDTH +: WIDTH] = y[c];
  end

  // Valid bits travel in lockstep with the data wavefront
  always_ff @(posedge clk) begin
    if (rst)          vld <= '0;
    else if (advance) vld <= {vld[DEPTH-2:0], accept};
  end

  // Control FSM: load weight rows, stream beats, drain before any weight reload
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w[r][c] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (w_valid) begin
            for (int c = 0; c < COLS; c++) w[cnt][c] <= w_data[c*WIDTH +: WIDTH];
            if (cnt == CW'(ROWS - 1)) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RUN:     if (w_valid) state <= DRAIN;
        DRAIN:   if (vld == '0) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for systolic_array at ROWS=COLS=2, WIDTH=16, FRAC_BIT=10.
// Covers reset, identity/uniform/negative/overflow math, latency, stall, reload and mid-stream reset.
// Results are captured by a handshake monitor and compared against hand-computed vectors.
`timescale 1ns/1ps
module tb_systolic_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  logic [31:0] got [$];
  logic [31:0] beats [6];
  logic [31:0] held;

  always #5 clk = ~clk;

  systolic_array #(.WIDTH(16), .FRAC_BIT(10), .ROWS(2), .COLS(2)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Record every result that will be consumed at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] r0, input logic [31:0] r1);
    w_valid = 1'b1;
    w_data  = r0;
    tick();
    w_data  = r1;
    tick();
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic reload(input string tag, input logic [31:0] r0, input logic [31:0] r1);
    int k;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    chk({tag, "_drain_wrdy"}, {31'd0, w_ready}, 32'd0);
    k = 0;
    while (!w_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_load_wrdy"}, {31'd0, w_ready}, 32'd1);
    load(r0, r1);
  endtask

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] exp);
    in_data  = a;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out_data"}, out_data, exp);
  endtask

  initial begin
    int i, t;
    logic acc;
    rst = 1'b1; w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_w_ready", {31'd0, w_ready}, 32'd1);
    tick();
    in_valid = 1'b0;

    // Identity weights
    load({16'h0000, 16'h0400}, {16'h0400, 16'h0000});
    single("ident", {16'h0600, 16'h0B00}, {16'h0600, 16'h0B00});

    reload("unif", {16'h0500, 16'h0500}, {16'h0500, 16'h0500});
    single("unif", {16'h0600, 16'h0B00}, {16'h1540, 16'h1540});

    reload("neg", {16'h0800, 16'h0800}, {16'h0800, 16'h0800});
    single("neg", {16'h0000, 16'hF300}, {16'hE600, 16'hE600});

    reload("ovf", {16'h7C00, 16'h7C00}, {16'h7C00, 16'h7C00});
`ifdef SYSTOLIC_SAT_EN
    single("ovf", {16'h7C00, 16'h7C00}, {16'h7FFF, 16'h7FFF});
`else
    single("ovf", {16'h7C00, 16'h7C00}, {16'h0800, 16'h0800});
`endif

    // Backpressure: six back-to-back beats with a 3-cycle stall
    reload("bp", {16'h0000, 16'h0400}, {16'h0400, 16'h0000});
    for (int k = 0; k < 6; k++) beats[k] = 32'h0010_0100 * (k + 1);
    got.delete();
    i = 0;
    held = '0;
    for (t = 0; t < 40; t++) begin
      out_ready = !(t >= 5 && t <= 7);
      in_valid  = (i < 6);
      in_data   = (i < 6) ? beats[i] : '0;
      #1;
      if (t >= 5 && t <= 7) begin
        chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_stall_out_valid", {31'd0, out_valid}, 32'd1);
        if (t == 5) held = out_data;
        else        chk("bp_hold_data", out_data, held);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      if (i == 6 && got.size() == 6) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got.size(), 32'd6);
    chk("bp_held_is_beat1", held, beats[1]);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) chk($sformatf("bp_order%0d", k), got[k], beats[k]);
      else                chk($sformatf("bp_order%0d", k), 32'hDEAD_DEAD, beats[k]);
    end

    // Reload with two beats in flight; the concurrent third beat must be refused
    got.delete();
    in_valid = 1'b1;
    in_data  = {16'h0200, 16'h0100};
    #1;
    chk("rl_acc0", {31'd0, in_ready}, 32'd1);
    tick();
    in_data = {16'h0400, 16'h0300};
    #1;
    chk("rl_acc1", {31'd0, in_ready}, 32'd1);
    tick();
    in_data = {16'h0FFF, 16'h0EEE};
    w_valid = 1'b1;
    #1;
    chk("rl_req_wins", {31'd0, in_ready}, 32'd0);
    tick();
    w_valid  = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rl_drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rl_drain_w_ready", {31'd0, w_ready}, 32'd0);
    in_valid = 1'b0;
    t = 0;
    while (!w_ready && t < 20) begin
      tick();
      t++;
    end
    chk("rl_w_ready", {31'd0, w_ready}, 32'd1);
    chk("rl_count", got.size(), 32'd2);
    if (got.size() >= 2) begin
      chk("rl_res0", got[0], {16'h0200, 16'h0100});
      chk("rl_res1", got[1], {16'h0400, 16'h0300});
    end
    load({16'h0500, 16'h0500}, {16'h0500, 16'h0500});
    single("rl_new", {16'h0600, 16'h0B00}, {16'h1540, 16'h1540});

    // Reset with beats in flight
    tick();
    got.delete();
    in_valid = 1'b1;
    in_data  = {16'h0600, 16'h0B00};
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_w_ready", {31'd0, w_ready}, 32'd1);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst_out_data", out_data, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    chk("mrst_no_stale", got.size(), 32'd0);
    load({16'h0000, 16'h0400}, {16'h0400, 16'h0000});
    single("mrst_after", {16'h0600, 16'h0B00}, {16'h0600, 16'h0B00});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
